// File: rtl/noc_pkg.sv
// noc_pkg: flit field widths, flit type codes, error codes and depacketizer states shared across the NoC
package noc_pkg;
    localparam int FLIT_DATA_WIDTH = 32;
    localparam int FLIT_TYPE_WIDTH = 2;
    localparam int FLIT_WIDTH = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH;
    localparam logic [1:0] FLIT_BODY = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_TAIL = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;
    localparam logic [1:0] ERR_ORPHAN = 2'b01;
    localparam logic [1:0] ERR_DUP_HEAD = 2'b10;
    localparam logic [1:0] ERR_LEN = 2'b11;
    typedef enum logic {S_IDLE, S_PAYLOAD} state_t;
endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous FIFO with full/empty flags; ports clk, rst, push/din, pop/dout, full, empty
module flit_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = empty ? '0 : mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/depacketization.sv
// depacketization: splits NoC flits into a header pulse and a last-framed payload stream via a small FIFO
// ports: in_valid/in_flit/in_ready flit input; hdr_valid/hdr_data header; out_valid/out_data/out_last/out_ready
// payload; err/err_code protocol errors; pkt_count completed packets. DEPACKETIZATION_LEN_CHECK_EN enables
// length checking against hdr_data[15:0].
module depacketization #(
    parameter int FLIT_DATA_WIDTH = noc_pkg::FLIT_DATA_WIDTH,
    parameter int FLIT_TYPE_WIDTH = noc_pkg::FLIT_TYPE_WIDTH,
    parameter int FLIT_WIDTH = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [FLIT_WIDTH-1:0]      in_flit,
    output logic                       in_ready,
    output logic                       hdr_valid,
    output logic [FLIT_DATA_WIDTH-1:0] hdr_data,
    output logic                       out_valid,
    output logic [FLIT_DATA_WIDTH-1:0] out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [15:0]                pkt_count
);
    import noc_pkg::*;
`ifdef DEPACKETIZATION_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif
    state_t state;
    logic [15:0] wcnt;
    logic [FLIT_TYPE_WIDTH-1:0] ftype;
    logic [FLIT_DATA_WIDTH-1:0] fdata;
    logic acc, push, full, empty, is_head, len_bad_tail, len_bad_single;
    assign ftype = in_flit[FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
    assign fdata = in_flit[FLIT_DATA_WIDTH-1:0];
    assign in_ready = !rst && (state == S_IDLE || !full);
    assign acc = in_valid && in_ready;
    assign is_head = ftype == FLIT_HEAD || ftype == FLIT_SINGLE;
    assign push = acc && state == S_PAYLOAD && !is_head;
    assign out_valid = !empty;
    // 17-bit compare so a saturated counter can never alias a 16-bit expected length
    assign len_bad_tail = LEN_CHK && ({1'b0, wcnt} + 17'd1 != {1'b0, hdr_data[15:0]});
    assign len_bad_single = LEN_CHK && fdata[15:0] != 16'd0;
    flit_fifo #(.WIDTH(FLIT_DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  ({ftype == FLIT_TAIL, fdata}),
        .pop  (out_ready),
        .dout ({out_last, out_data}),
        .full (full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt <= '0;
            hdr_valid <= 1'b0;
            hdr_data <= '0;
            err <= 1'b0;
            err_code <= '0;
            pkt_count <= '0;
        end else begin
            hdr_valid <= 1'b0;
            err <= 1'b0;
            if (acc) begin
                if (state == S_IDLE) begin
                    if (is_head) begin
                        hdr_data <= fdata;
                        hdr_valid <= 1'b1;
                        wcnt <= '0;
                        if (ftype == FLIT_HEAD) begin
                            state <= S_PAYLOAD;
                        end else begin
                            pkt_count <= pkt_count + 16'd1;
                            if (len_bad_single) begin
                                err <= 1'b1;
                                err_code <= ERR_LEN;
                            end
                        end
                    end else begin
                        err <= 1'b1;
                        err_code <= ERR_ORPHAN;
                    end
                end else if (is_head) begin
                    err <= 1'b1;
                    err_code <= ERR_DUP_HEAD;
                end else begin
                    wcnt <= wcnt == 16'hFFFF ? wcnt : wcnt + 16'd1;
                    if (ftype == FLIT_TAIL) begin
                        state <= S_IDLE;
                        pkt_count <= pkt_count + 16'd1;
                        if (len_bad_tail) begin
                            err <= 1'b1;
                            err_code <= ERR_LEN;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_depacketization.sv
// tb_depacketization: randomized and directed stimulus checked against a packet-level reference model
module tb_depacketization;
`ifdef DEPACKETIZATION_LEN_CHECK_EN
    localparam bit LEN = 1'b1;
`else
    localparam bit LEN = 1'b0;
`endif
    localparam int FD = 4;
    logic clk, rst, in_valid, in_ready, hdr_valid, out_valid, out_last, out_ready, err;
    logic [33:0] in_flit;
    logic [31:0] hdr_data, out_data;
    logic [1:0] err_code;
    logic [15:0] pkt_count;
    int checks = 0, failures = 0;
    logic [32:0] q[$];
    bit m_pkt, pend_hv, pend_err, acc;
    logic [31:0] m_hdr;
    logic [1:0] m_code;
    logic [15:0] m_cnt;
    int m_words;

    depacketization #(.FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
        .hdr_valid(hdr_valid), .hdr_data(hdr_data), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .err(err), .err_code(err_code), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic raise(input logic [1:0] c);
        pend_err = 1'b1;
        m_code = c;
    endtask

    // Packet-level model: a head opens a packet, body/tail words queue up, tail or single completes it.
    task automatic model(input logic [33:0] f);
        logic [1:0] t;
        logic [31:0] d;
        t = f[33:32];
        d = f[31:0];
        if (t == 2'b01 || t == 2'b11) begin
            if (m_pkt) raise(2'b10);
            else begin
                m_hdr = d;
                pend_hv = 1'b1;
                m_words = 0;
                if (t == 2'b01) m_pkt = 1'b1;
                else begin
                    m_cnt = m_cnt + 16'd1;
                    if (LEN && d[15:0] != 16'd0) raise(2'b11);
                end
            end
        end else if (!m_pkt) raise(2'b01);
        else begin
            m_words++;
            q.push_back({t == 2'b10, d});
            if (t == 2'b10) begin
                m_pkt = 1'b0;
                m_cnt = m_cnt + 16'd1;
                if (LEN && m_words != int'(m_hdr[15:0])) raise(2'b11);
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [33:0] f, input bit ordy, input bit r);
        @(negedge clk);
        chk("hdr_valid", hdr_valid, pend_hv);
        chk("hdr_data", hdr_data, m_hdr);
        chk("err", err, pend_err);
        chk("err_code", err_code, m_code);
        chk("out_valid", out_valid, q.size() != 0);
        chk("pkt_count", pkt_count, m_cnt);
        pend_hv = 1'b0;
        pend_err = 1'b0;
        rst = r;
        in_valid = v;
        in_flit = f;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !r && (!m_pkt || q.size() < FD));
        acc = !r && in_valid && in_ready;
        if (r) begin
            q.delete();
            m_pkt = 1'b0;
            m_cnt = '0;
            m_hdr = '0;
            m_code = '0;
        end else begin
            if (out_valid && out_ready && q.size() != 0) chk("out_word", {out_last, out_data}, q.pop_front());
            if (acc) model(f);
        end
    endtask

    task automatic send(input logic [1:0] t, input logic [31:0] d, input bit ordy);
        int n = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            cyc(1'b1, {t, d}, ordy, 1'b0);
            n++;
        end
        chk("send_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n, input bit ordy);
        repeat (n) cyc(1'b0, '0, ordy, 1'b0);
    endtask

    function automatic logic [33:0] rand_flit();
        logic [1:0] t;
        logic [31:0] d;
        int p;
        p = $urandom_range(0, 9);
        t = p < 4 ? 2'b00 : p < 6 ? 2'b10 : p < 8 ? 2'b01 : 2'b11;
        d = $urandom;
        if (t[0] && $urandom_range(0, 1) == 1) d[15:0] = 16'($urandom_range(0, 3));
        return {t, d};
    endfunction

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_flit = '0;
        out_ready = 1'b0;
        m_pkt = 1'b0;
        pend_hv = 1'b0;
        pend_err = 1'b0;
        m_hdr = '0;
        m_code = '0;
        m_cnt = '0;
        m_words = 0;
        repeat (2) @(posedge clk);
        send(2'b01, 32'h00AA0002, 1'b1);
        send(2'b00, 32'h11, 1'b1);
        send(2'b10, 32'h22, 1'b1);
        idle(4, 1'b1);
        send(2'b01, 32'h6, 1'b0);
        for (int i = 1; i <= 4; i++) send(2'b00, i, 1'b0);
        repeat (3) begin
            cyc(1'b1, {2'b00, 32'h5}, 1'b0, 1'b0);
            chk("full_stall", acc, 1'b0);
        end
        send(2'b00, 32'h5, 1'b1);
        send(2'b00, 32'h6, 1'b1);
        idle(6, 1'b1);
        send(2'b10, 32'h7, 1'b1);
        idle(3, 1'b1);
        send(2'b00, 32'h5, 1'b1);
        send(2'b01, 32'h1, 1'b1);
        send(2'b10, 32'h33, 1'b1);
        idle(3, 1'b1);
        send(2'b01, 32'h1, 1'b1);
        send(2'b01, 32'h2, 1'b1);
        send(2'b10, 32'h9, 1'b1);
        idle(3, 1'b1);
        send(2'b11, 32'h0, 1'b1);
        send(2'b01, 32'h3, 1'b1);
        send(2'b10, 32'h44, 1'b1);
        idle(3, 1'b1);
        send(2'b01, 32'h3, 1'b0);
        for (int i = 0; i < 3; i++) send(2'b00, 32'h100 + i, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle(2, 1'b1);
        send(2'b10, 32'h55, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 3) != 0, rand_flit(), $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
        idle(8, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
